max_track_arbiter: RTL and testbench

MAX_TRACK_ARBITER -- requirements
Module: max_track_arbiter

---
 rtl/max_track_arbiter_if.sv | 25 ++
 rtl/max_track_arbiter.sv | 108 ++++++++++
 tb/tb_max_track_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/max_track_arbiter_if.sv
// Purpose: bundles the request/sample/clear inputs and grant/max outputs of max_track_arbiter.
// Latency: none; wires only.
// Backpressure: none; the requester holds req/val until it sees gnt.
// Ports: req[3:0], val[7:0] (2 bits per requester), clr[3:0] from the requesters;
//        gnt[3:0], busy, ch_max[7:0], glob_max[1:0], glob_id[1:0] back from the arbiter.
interface max_track_arbiter_if;
  logic [3:0] req;
  logic [7:0] val;
  logic [3:0] clr;
  logic [3:0] gnt;
  logic       busy;
  logic [7:0] ch_max;
  logic [1:0] glob_max;
  logic [1:0] glob_id;

  modport master (
    output req, val, clr,
    input  gnt, busy, ch_max, glob_max, glob_id
  );

  modport slave (
    input  req, val, clr,
    output gnt, busy, ch_max, glob_max, glob_id
  );
endinterface

// File: rtl/max_track_arbiter.sv
// Purpose: round-robin arbiter over 4 requesters that folds each granted 2-bit sample into a per-requester running max.
// Latency: req->gnt 1 edge, req->ch_max update 3 edges; one grant every 3 cycles; glob_max/glob_id combinational.
// Backpressure: requesters hold req/val until gnt; no grant is issued while busy (GRANT/COMMIT).
// Ports: clk, rst (sync, active-high); bus (slave modport): req, val, clr in; gnt, busy, ch_max, glob_max, glob_id out.
module max_track_arbiter (
  input  logic                clk,
  input  logic                rst,
  max_track_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      ptr;
  logic [1:0]      winner;
  logic [1:0]      sample;
  logic [3:0]      gnt_q;
  logic [3:0][1:0] ch_q;

  logic [1:0]      pick;
  logic            pick_vld;
  logic [1:0]      idx;
  logic [1:0]      gmax;
  logic [1:0]      gid;

  // Round-robin pick: scan from ptr upward, wrapping 3 -> 0 through 2-bit overflow.
  always_comb begin
    pick     = 2'd0;
    pick_vld = 1'b0;
    idx      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + k[1:0];
      if (!pick_vld && bus.req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = GRANT;
      GRANT:   state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= 2'd0;
      winner <= 2'd0;
      sample <= 2'd0;
      gnt_q  <= 4'd0;
      ch_q   <= '0;
    end else begin
      gnt_q <= 4'd0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            winner <= pick;
            gnt_q  <= 4'b0001 << pick;
          end
        end
        GRANT: sample <= bus.val[{winner, 1'b0} +: 2];
        COMMIT: begin
          ptr <= winner + 2'd1;
          if (sample > ch_q[winner]) ch_q[winner] <= sample;
        end
        default: ;
      endcase
      // Placed after the commit update so a same-edge clear takes precedence.
      for (int i = 0; i < 4; i++) begin
        if (bus.clr[i]) ch_q[i] <= 2'd0;
      end
    end
  end

  // Strict '>' keeps the lowest index on ties; all-zero yields max 0, id 0.
  always_comb begin
    gmax = ch_q[0];
    gid  = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (ch_q[i] > gmax) begin
        gmax = ch_q[i];
        gid  = i[1:0];
      end
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.busy     = (state != IDLE);
  assign bus.ch_max   = ch_q;
  assign bus.glob_max = gmax;
  assign bus.glob_id  = gid;

endmodule

// File: tb/tb_max_track_arbiter.sv
// Purpose: directed checks of max_track_arbiter grant sequencing, running-max update, clear and reset behaviour.
// Latency: outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure: every scenario advances a fixed number of edges, so the run always terminates.
module tb_max_track_arbiter;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  max_track_arbiter_if bus ();

  max_track_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req = 4'd0;
    bus.clr = 4'd0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Drive-only: one complete transaction for requester i with sample v.
  task automatic submit(input int i, input logic [1:0] v);
    bus.req = 4'b0001 << i;
    bus.val = 8'(v) << (2 * i);
    step();
    bus.req = 4'd0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'b1111;
    bus.val = 8'hFF;
    bus.clr = 4'b0000;
    step();
    step();
    vectors++; if (bus.gnt !== 4'd0) begin miscompares++; $display("FAIL reset_gnt got %b exp %b", bus.gnt, 4'd0); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp %b", bus.busy, 1'b0); end
    vectors++; if (bus.ch_max !== 8'h00) begin miscompares++; $display("FAIL reset_ch_max got %h exp %h", bus.ch_max, 8'h00); end
    vectors++; if (bus.glob_max !== 2'd0) begin miscompares++; $display("FAIL reset_glob_max got %0d exp %0d", bus.glob_max, 0); end
    vectors++; if (bus.glob_id !== 2'd0) begin miscompares++; $display("FAIL reset_glob_id got %0d exp %0d", bus.glob_id, 0); end
  endtask

  task automatic test_single();
    rst = 1'b0;
    bus.req = 4'b0001;
    bus.val = 8'h02;
    step();
    vectors++; if (bus.gnt !== 4'b0001) begin miscompares++; $display("FAIL single_gnt got %b exp %b", bus.gnt, 4'b0001); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_grant got %b exp %b", bus.busy, 1'b1); end
    bus.req = 4'd0;
    step();
    vectors++; if (bus.gnt !== 4'd0) begin miscompares++; $display("FAIL single_gnt_commit got %b exp %b", bus.gnt, 4'd0); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_commit got %b exp %b", bus.busy, 1'b1); end
    vectors++; if (bus.ch_max !== 8'h00) begin miscompares++; $display("FAIL single_early_ch_max got %h exp %h", bus.ch_max, 8'h00); end
    step();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_idle got %b exp %b", bus.busy, 1'b0); end
    vectors++; if (bus.ch_max !== 8'h02) begin miscompares++; $display("FAIL single_ch_max got %h exp %h", bus.ch_max, 8'h02); end
    vectors++; if (bus.glob_max !== 2'd2) begin miscompares++; $display("FAIL single_glob_max got %0d exp %0d", bus.glob_max, 2); end
    vectors++; if (bus.glob_id !== 2'd0) begin miscompares++; $display("FAIL single_glob_id got %0d exp %0d", bus.glob_id, 0); end
    step();
    vectors++; if (bus.gnt !== 4'd0) begin miscompares++; $display("FAIL idle_no_req_gnt got %b exp %b", bus.gnt, 4'd0); end
  endtask

  task automatic test_round_robin();
    logic [3:0] e;
    do_reset();
    bus.req = 4'b1111;
    bus.val = 8'hE4;
    for (int g = 0; g < 5; g++) begin
      e = 4'b0001 << (g % 4);
      step();
      vectors++; if (bus.gnt !== e) begin miscompares++; $display("FAIL rr_gnt[%0d] got %b exp %b", g, bus.gnt, e); end
      step();
      vectors++; if (bus.gnt !== 4'd0) begin miscompares++; $display("FAIL rr_gap1[%0d] got %b exp %b", g, bus.gnt, 4'd0); end
      step();
      vectors++; if (bus.gnt !== 4'd0) begin miscompares++; $display("FAIL rr_gap2[%0d] got %b exp %b", g, bus.gnt, 4'd0); end
    end
    bus.req = 4'd0;
    vectors++; if (bus.ch_max !== 8'hE4) begin miscompares++; $display("FAIL rr_ch_max got %h exp %h", bus.ch_max, 8'hE4); end
    vectors++; if (bus.glob_max !== 2'd3) begin miscompares++; $display("FAIL rr_glob_max got %0d exp %0d", bus.glob_max, 3); end
    vectors++; if (bus.glob_id !== 2'd3) begin miscompares++; $display("FAIL rr_glob_id got %0d exp %0d", bus.glob_id, 3); end
  endtask

  task automatic test_hold_and_clear();
    do_reset();
    submit(0, 2'd2);
    submit(2, 2'd2);
    submit(1, 2'd3);
    vectors++; if (bus.ch_max[3:2] !== 2'd3) begin miscompares++; $display("FAIL hold_first got %0d exp %0d", bus.ch_max[3:2], 3); end
    submit(1, 2'd1);
    vectors++; if (bus.ch_max[3:2] !== 2'd3) begin miscompares++; $display("FAIL hold_lower got %0d exp %0d", bus.ch_max[3:2], 3); end
    submit(1, 2'd2);
    vectors++; if (bus.ch_max !== 8'h2E) begin miscompares++; $display("FAIL hold_ch_max got %h exp %h", bus.ch_max, 8'h2E); end
    vectors++; if (bus.glob_id !== 2'd1) begin miscompares++; $display("FAIL hold_glob_id got %0d exp %0d", bus.glob_id, 1); end
    bus.clr = 4'b0010;
    step();
    bus.clr = 4'd0;
    vectors++; if (bus.ch_max !== 8'h22) begin miscompares++; $display("FAIL clr_ch_max got %h exp %h", bus.ch_max, 8'h22); end
    vectors++; if (bus.glob_max !== 2'd2) begin miscompares++; $display("FAIL clr_glob_max got %0d exp %0d", bus.glob_max, 2); end
    vectors++; if (bus.glob_id !== 2'd0) begin miscompares++; $display("FAIL clr_glob_id got %0d exp %0d", bus.glob_id, 0); end
  endtask

  task automatic test_clr_collision();
    bus.req = 4'b0100;
    bus.val = 8'h30;
    step();
    vectors++; if (bus.gnt !== 4'b0100) begin miscompares++; $display("FAIL coll_gnt got %b exp %b", bus.gnt, 4'b0100); end
    bus.req = 4'd0;
    step();
    bus.clr = 4'b0100;
    step();
    bus.clr = 4'd0;
    vectors++; if (bus.ch_max !== 8'h02) begin miscompares++; $display("FAIL coll_ch_max got %h exp %h", bus.ch_max, 8'h02); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL coll_busy got %b exp %b", bus.busy, 1'b0); end
  endtask

  task automatic test_rst_abort();
    bus.req = 4'b1000;
    bus.val = 8'hC0;
    step();
    vectors++; if (bus.gnt !== 4'b1000) begin miscompares++; $display("FAIL abort_pre_gnt got %b exp %b", bus.gnt, 4'b1000); end
    rst = 1'b1;
    step();
    vectors++; if (bus.gnt !== 4'd0) begin miscompares++; $display("FAIL abort_gnt got %b exp %b", bus.gnt, 4'd0); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b exp %b", bus.busy, 1'b0); end
    vectors++; if (bus.ch_max !== 8'h00) begin miscompares++; $display("FAIL abort_ch_max got %h exp %h", bus.ch_max, 8'h00); end
    rst = 1'b0;
    step();
    vectors++; if (bus.gnt !== 4'b1000) begin miscompares++; $display("FAIL abort_regrant got %b exp %b", bus.gnt, 4'b1000); end
    bus.req = 4'd0;
    step();
    vectors++; if (bus.ch_max !== 8'h00) begin miscompares++; $display("FAIL abort_no_commit got %h exp %h", bus.ch_max, 8'h00); end
    step();
    vectors++; if (bus.ch_max !== 8'hC0) begin miscompares++; $display("FAIL abort_recommit got %h exp %h", bus.ch_max, 8'hC0); end
    vectors++; if (bus.glob_id !== 2'd3) begin miscompares++; $display("FAIL abort_glob_id got %0d exp %0d", bus.glob_id, 3); end
  endtask

  task automatic test_ties();
    do_reset();
    submit(1, 2'd3);
    submit(2, 2'd3);
    submit(3, 2'd1);
    vectors++; if (bus.ch_max !== 8'h7C) begin miscompares++; $display("FAIL tie_ch_max got %h exp %h", bus.ch_max, 8'h7C); end
    vectors++; if (bus.glob_max !== 2'd3) begin miscompares++; $display("FAIL tie_glob_max got %0d exp %0d", bus.glob_max, 3); end
    vectors++; if (bus.glob_id !== 2'd1) begin miscompares++; $display("FAIL tie_glob_id got %0d exp %0d", bus.glob_id, 1); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst     = 1'b1;
    bus.req = 4'd0;
    bus.val = 8'h00;
    bus.clr = 4'd0;
    test_reset();
    test_single();
    test_round_robin();
    test_hold_and_clear();
    test_clr_collision();
    test_rst_abort();
    test_ties();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
